// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch port and the load/store port.
// One access at a time, fixed-latency sequencing, registered one-cycle acks.
module mem_port_arbiter #(
    parameter int RAM_AW   = 10,
    parameter int RAM_LAT  = 1,
    parameter int MAX_SKIP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_half,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] MAX_SKIP_C = 3'(MAX_SKIP);
    localparam logic [2:0] RAM_LAT_C  = 3'(RAM_LAT);

    state_t            state_r, state_s;
    logic [2:0]        skip_r, skip_s;
    logic [2:0]        lat_r, lat_s;
    logic              own_dm_r, own_dm_s;
    logic              half_r, half_s;
    logic              hi_r, hi_s;
    logic              ram_en_r, ram_en_s;
    logic              ram_we_r, ram_we_s;
    logic              we_r, we_s;
    logic [3:0]        ram_be_r, ram_be_s;
    logic [RAM_AW-1:0] ram_addr_r, ram_addr_s;
    logic [31:0]       ram_wdata_r, ram_wdata_s;
    logic              if_ack_r, if_ack_s;
    logic              dm_ack_r, dm_ack_s;
    logic              dm_err_r, dm_err_s;
    logic [31:0]       if_rdata_r, if_rdata_s;
    logic [31:0]       dm_rdata_r, dm_rdata_s;
    logic              busy_r, busy_s;
    logic              dm_misaligned_s;
    logic              unused_s;

    assign unused_s = ^{if_addr[31:RAM_AW+2], if_addr[1:0], dm_addr[31:RAM_AW+2]};

    // Half-word loads return the addressed lane zero-extended.
    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic half,
                                             input logic hi);
        logic [31:0] r;
        if (!half) begin
            r = d;
        end else if (hi) begin
            r = {16'h0000, d[31:16]};
        end else begin
            r = {16'h0000, d[15:0]};
        end
        return r;
    endfunction

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_s     = state_r;
        skip_s      = skip_r;
        lat_s       = lat_r;
        own_dm_s    = own_dm_r;
        half_s      = half_r;
        hi_s        = hi_r;
        we_s        = we_r;
        ram_be_s    = ram_be_r;
        ram_addr_s  = ram_addr_r;
        ram_wdata_s = ram_wdata_r;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        if_ack_s    = 1'b0;
        dm_ack_s    = 1'b0;
        dm_err_s    = 1'b0;
        dm_misaligned_s = dm_half ? dm_addr[0] : (dm_addr[1:0] != 2'b00);

        case (state_r)
            IDLE: begin
                if (if_req && (!dm_req || (skip_r == MAX_SKIP_C))) begin
                    own_dm_s    = 1'b0;
                    we_s        = 1'b0;
                    half_s      = 1'b0;
                    hi_s        = 1'b0;
                    ram_be_s    = 4'b1111;
                    ram_addr_s  = if_addr[RAM_AW+1:2];
                    skip_s      = 3'd0;
                    ram_en_s    = 1'b1;
                    state_s     = ISSUE;
                end else if (dm_req) begin
                    own_dm_s = 1'b1;
                    // IF lost this round; never counts past the forcing threshold.
                    if (if_req && (skip_r != MAX_SKIP_C)) begin
                        skip_s = skip_r + 3'd1;
                    end else begin
                        skip_s = skip_r;
                    end
                    if (dm_misaligned_s) begin
                        dm_ack_s   = 1'b1;
                        dm_err_s   = 1'b1;
                        dm_rdata_s = 32'h0000_0000;
                        state_s    = RESP;
                    end else begin
                        we_s        = dm_we;
                        half_s      = dm_half;
                        hi_s        = dm_addr[1];
                        ram_addr_s  = dm_addr[RAM_AW+1:2];
                        ram_wdata_s = dm_half ? {dm_wdata[15:0], dm_wdata[15:0]} : dm_wdata;
                        if (!dm_half) begin
                            ram_be_s = 4'b1111;
                        end else if (dm_addr[1]) begin
                            ram_be_s = 4'b1100;
                        end else begin
                            ram_be_s = 4'b0011;
                        end
                        ram_en_s = 1'b1;
                        ram_we_s = dm_we;
                        state_s  = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                lat_s   = RAM_LAT_C;
                state_s = WAIT;
            end
            WAIT: begin
                lat_s = lat_r - 3'd1;
                if (lat_r == 3'd1) begin
                    if (!own_dm_r) begin
                        if_rdata_s = ram_rdata;
                        if_ack_s   = 1'b1;
                    end else if (!we_r) begin
                        dm_rdata_s = fmt_load(ram_rdata, half_r, hi_r);
                        dm_ack_s   = 1'b1;
                    end else begin
                        dm_ack_s   = 1'b1;
                    end
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            skip_r      <= 3'd0;
            lat_r       <= 3'd0;
            own_dm_r    <= 1'b0;
            half_r      <= 1'b0;
            hi_r        <= 1'b0;
            we_r        <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_be_r    <= 4'b0000;
            ram_addr_r  <= '0;
            ram_wdata_r <= 32'h0000_0000;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            dm_err_r    <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            skip_r      <= skip_s;
            lat_r       <= lat_s;
            own_dm_r    <= own_dm_s;
            half_r      <= half_s;
            hi_r        <= hi_s;
            we_r        <= we_s;
            ram_en_r    <= ram_en_s;
            ram_we_r    <= ram_we_s;
            ram_be_r    <= ram_be_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
            if_ack_r    <= if_ack_s;
            dm_ack_r    <= dm_ack_s;
            dm_err_r    <= dm_err_s;
            if_rdata_r  <= if_rdata_s;
            dm_rdata_r  <= dm_rdata_s;
            busy_r      <= busy_s;
        end
    end

    assign if_ack    = if_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_ack    = dm_ack_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_err    = dm_err_r;
    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_be    = ram_be_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign busy      = busy_r;

endmodule
